// File: rtl/fmap_streamer.sv
// fmap_streamer: reads a 28x28 / 12x12 byte feature map in raster order and feeds a 5-row sliding window.
// Optional feature macro: STREAMER_FLUSH_EN appends W-1 zero pixels so the last window row completes.
module fmap_streamer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              state,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] din,
    output logic              start,
    output logic              tap_valid,
    output logic [4:0]        tap_row,
    output logic [4:0]        tap_col,
    output logic              win_valid,
    output logic              busy,
    output logic              done
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned POS_W = 5;

`ifdef STREAMER_FLUSH_EN
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_DONE} fsm_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fsm_e;
`endif

    fsm_e              fsm_q, fsm_d;
    logic              w12_q, w12_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [CNT_W-1:0]  kcur_q, kcur_d;
    logic [POS_W-1:0]  pr_q, pr_d;
    logic [POS_W-1:0]  pc_q, pc_d;
    logic              vld_q, vld_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              start_q, start_d;
    logic              tap_valid_q, tap_valid_d;
    logic [POS_W-1:0]  tap_row_q, tap_row_d;
    logic [POS_W-1:0]  tap_col_q, tap_col_d;
    logic              win_valid_q, win_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] last_addr;
    logic [CNT_W-1:0]  first_tap;
    logic [POS_W-1:0]  w_m1;
`ifdef STREAMER_FLUSH_EN
    logic [CNT_W-1:0]  flush_last;
`endif

    // Frame geometry for the width latched at go.
    always_comb begin
        if (w12_q) begin
            last_addr  = ADDR_W'(143);
            first_tap  = CNT_W'(59);
            w_m1       = POS_W'(11);
`ifdef STREAMER_FLUSH_EN
            flush_last = CNT_W'(154);
`endif
        end else begin
            last_addr  = ADDR_W'(783);
            first_tap  = CNT_W'(139);
            w_m1       = POS_W'(27);
`ifdef STREAMER_FLUSH_EN
            flush_last = CNT_W'(810);
`endif
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        w12_d       = w12_q;
        cnt_d       = cnt_q;
        pix_d       = pix_q;
        kcur_d      = kcur_q;
        pr_d        = pr_q;
        pc_d        = pc_q;
        vld_d       = rd_en_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        din_d       = din_q;
        start_d     = 1'b0;
        tap_valid_d = 1'b0;
        tap_row_d   = tap_row_q;
        tap_col_d   = tap_col_q;
        win_valid_d = 1'b0;
        done_d      = 1'b0;

        // A landed RAM word becomes the next window pixel.
        if (vld_q) begin
            din_d   = rd_data;
            start_d = 1'b1;
            kcur_d  = pix_q;
            pix_d   = pix_q + CNT_W'(1);
        end

        // Taps hold a full column once 5W-1 pixels have been shifted in.
        if (start_q && (kcur_q >= first_tap)) begin
            tap_valid_d = 1'b1;
            tap_row_d   = pr_q;
            tap_col_d   = pc_q;
            win_valid_d = (pc_q >= POS_W'(4));
            if (pc_q == w_m1) begin
                pc_d = '0;
                pr_d = pr_q + POS_W'(1);
            end else begin
                pc_d = pc_q + POS_W'(1);
            end
        end

        unique case (fsm_q)
            S_IDLE: begin
                if (go) begin
                    fsm_d = S_RUN;
                    w12_d = state;
                    cnt_d = '0;
                    pix_d = '0;
                    pr_d  = '0;
                    pc_d  = '0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = cnt_q;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (cnt_q == last_addr) begin
                        fsm_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (vld_q && (pix_q == CNT_W'(last_addr))) begin
`ifdef STREAMER_FLUSH_EN
                    fsm_d = S_FLUSH;
`else
                    fsm_d = S_DONE;
`endif
                end
            end
`ifdef STREAMER_FLUSH_EN
            S_FLUSH: begin
                din_d   = '0;
                start_d = 1'b1;
                kcur_d  = pix_q;
                pix_d   = pix_q + CNT_W'(1);
                if (pix_q == flush_last) begin
                    fsm_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done_d = 1'b1;
                fsm_d  = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase

        busy_d = (fsm_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            w12_q       <= 1'b0;
            cnt_q       <= '0;
            pix_q       <= '0;
            kcur_q      <= '0;
            pr_q        <= '0;
            pc_q        <= '0;
            vld_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            din_q       <= '0;
            start_q     <= 1'b0;
            tap_valid_q <= 1'b0;
            tap_row_q   <= '0;
            tap_col_q   <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            w12_q       <= w12_d;
            cnt_q       <= cnt_d;
            pix_q       <= pix_d;
            kcur_q      <= kcur_d;
            pr_q        <= pr_d;
            pc_q        <= pc_d;
            vld_q       <= vld_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            din_q       <= din_d;
            start_q     <= start_d;
            tap_valid_q <= tap_valid_d;
            tap_row_q   <= tap_row_d;
            tap_col_q   <= tap_col_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign din       = din_q;
    assign start     = start_q;
    assign tap_valid = tap_valid_q;
    assign tap_row   = tap_row_q;
    assign tap_col   = tap_col_q;
    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_fmap_streamer.sv
// Scoreboard bench for fmap_streamer: random feature maps and hold patterns against a raster-order reference.
// Honours STREAMER_FLUSH_EN when deciding expected pixel/tap counts.
module tb_fmap_streamer;
    logic       clk;
    logic       rst;
    logic       go;
    logic       st;
    logic       hold;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] din;
    logic       start;
    logic       tap_valid;
    logic [4:0] tap_row;
    logic [4:0] tap_col;
    logic       win_valid;
    logic       busy;
    logic       done;

    fmap_streamer #(.DATA_W(8), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .go(go), .state(st), .hold(hold),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .din(din), .start(start), .tap_valid(tap_valid),
        .tap_row(tap_row), .tap_col(tap_col), .win_valid(win_valid),
        .busy(busy), .done(done)
    );

    typedef struct {
        int row;
        int col;
        bit win;
    } tap_t;

    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] mem [0:1023];
    logic [7:0] exp_pix [$];
    tap_t exp_tap [$];
    int   tb_w = 28;
    int   exp_addr = 0;
    int   hold_pct = 0;
    int   cyc = 0;
    int   n_start, n_tap, n_win, n_done;
    int   first_rd_cyc, first_st_cyc, last_row, last_col;
    bit   prev_start = 1'b0;
    int   prev_k = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read RAM: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            hold = (hold_pct > 0) && (int'($urandom_range(99)) < hold_pct);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops and compares whatever the DUT presents.
    always @(negedge clk) begin
        tap_t e;
        logic [7:0] ep;
        cyc++;
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                chk("rd_addr", int'(rd_addr), exp_addr);
                exp_addr++;
            end
            if (prev_start || tap_valid)
                chk("tap_valid", int'(tap_valid), int'(prev_start && (prev_k >= 5 * tb_w - 1)));
            if (tap_valid) begin
                n_tap++;
                chk("tap_q_nonempty", int'(exp_tap.size() != 0), 1);
                if (exp_tap.size() != 0) begin
                    e = exp_tap.pop_front();
                    chk("tap_row", int'(tap_row), e.row);
                    chk("tap_col", int'(tap_col), e.col);
                    chk("win_valid", int'(win_valid), int'(e.win));
                end
                last_row = int'(tap_row);
                last_col = int'(tap_col);
            end else if (win_valid) begin
                chk("win_without_tap", int'(win_valid), 0);
            end
            if (win_valid) n_win++;
            if (start) begin
                n_start++;
                if (first_st_cyc < 0) first_st_cyc = cyc;
                chk("pix_q_nonempty", int'(exp_pix.size() != 0), 1);
                if (exp_pix.size() != 0) begin
                    ep = exp_pix.pop_front();
                    chk("din", int'(din), int'(ep));
                end
                prev_k = n_start - 1;
            end
            prev_start = start;
            if (done) n_done++;
        end
    end

    // Reference model: raster pixels, optional zero flush, tap positions counted from 5W-1.
    task automatic setup_frame(input bit w12, input bit ramp);
        int w;
        int npix;
        w = w12 ? 12 : 28;
        tb_w = w;
        exp_pix.delete();
        exp_tap.delete();
        for (int i = 0; i < w * w; i++) begin
            mem[i] = ramp ? 8'(i) : 8'($urandom_range(255));
            exp_pix.push_back(mem[i]);
        end
        npix = w * w;
`ifdef STREAMER_FLUSH_EN
        for (int i = 0; i < w - 1; i++) exp_pix.push_back(8'd0);
        npix = w * w + w - 1;
`endif
        for (int p = 0; p < npix - (5 * w - 1); p++) begin
            tap_t t;
            t.row = p / w;
            t.col = p % w;
            t.win = (t.col >= 4);
            exp_tap.push_back(t);
        end
        exp_addr = 0;
        n_start = 0; n_tap = 0; n_win = 0; n_done = 0;
        first_rd_cyc = -1; first_st_cyc = -1; last_row = -1; last_col = -1;
    endtask

    task automatic pulse_go(input bit s);
        @(negedge clk);
        #1;
        st = s;
        go = 1'b1;
        @(negedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic run_frame(input bit w12, input int hp, input bit ramp, input bit glitch);
        int n;
        int w;
        int etap, ewin, estart, ecol;
        w = w12 ? 12 : 28;
`ifdef STREAMER_FLUSH_EN
        etap = w12 ? 96 : 672;
        ewin = w12 ? 64 : 576;
        estart = w * w + w - 1;
        ecol = w - 1;
`else
        etap = w12 ? 85 : 645;
        ewin = w12 ? 56 : 552;
        estart = w * w;
        ecol = 0;
`endif
        setup_frame(w12, ramp);
        hold_pct = hp;
        pulse_go(w12);
        if (glitch) begin
            repeat (9) @(negedge clk);
            #1;
            st = ~w12;
            repeat (9) @(negedge clk);
            pulse_go(~w12);
        end
        n = 0;
        while (n_done == 0 && n < 6000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_timeout", int'(n_done != 0), 1);
        repeat (4) @(negedge clk);
        #1;
        hold_pct = 0;
        chk("done_count", n_done, 1);
        chk("busy_idle", int'(busy), 0);
        chk("start_count", n_start, estart);
        chk("tap_count", n_tap, etap);
        chk("win_count", n_win, ewin);
        chk("last_tap_row", last_row, w - 5);
        chk("last_tap_col", last_col, ecol);
        chk("addr_issued", exp_addr, w * w);
        chk("pix_left", exp_pix.size(), 0);
        chk("tap_left", exp_tap.size(), 0);
        chk("start_latency", first_st_cyc - first_rd_cyc, 2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, int'(rd_addr), 0);
        chk({tag, "_din"}, int'(din), 0);
        chk({tag, "_ctl"}, int'({rd_en, start, tap_valid, win_valid, busy, done}), 0);
        chk({tag, "_pos"}, int'({tap_row, tap_col}), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        go = 1'b0;
        st = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Abort a W=28 frame when address 300 is issued.
        setup_frame(1'b0, 1'b0);
        pulse_go(1'b0);
        n = 0;
        while (!(rd_en && rd_addr == 10'd300) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reach_300", int'(rd_en && rd_addr == 10'd300), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        #1;
        chk_all_zero("abort_next");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_idle", int'({busy, rd_en, start}), 0);

        run_frame(1'b0, 0, 1'b0, 1'b0);   // restart from address 0 after abort
        run_frame(1'b1, 0, 1'b1, 1'b0);   // ramp, W=12, no backpressure
        run_frame(1'b0, 50, 1'b0, 1'b0);  // W=28, 50% hold
        run_frame(1'b1, 0, 1'b0, 1'b1);   // state change + extra go mid-frame
        for (int i = 0; i < 4; i++)
            run_frame(1'($urandom_range(1)), int'($urandom_range(2)) * 35, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
